uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver, downstream peer of the UART transmitter. Samples the asynchronous RX line, frames
//  start / DATA_WIDTH data (LSB first) / STOP_BIT_SIZE stop bits, and presents each byte with a
//  1-cycle valid pulse. Frame format and parameters match the transmitter so the two loop back directly.
// PARAMETERS
//  CLK_FREQ       50000000  system clock frequency, Hz
//  BAUDRATE       9600      line bit rate, bit/s
//  DATA_WIDTH     8         data bits per frame
//  STOP_BIT_SIZE  1         stop bits per frame (1 or 2)
//  OVERSAMPLE     16        sample ticks per bit; localparam TICK_DIV = CLK_FREQ/(BAUDRATE*OVERSAMPLE), must be >=1
// PORTS
//  clk        in   1           system clock, all logic on posedge
//  rst_n      in   1           synchronous reset, active low
//  line       in   1           asynchronous RX line, idle high
//  data       out  DATA_WIDTH  last good received word; holds until next good frame
//  valid      out  1           1-cycle pulse, data updated in same cycle
//  frame_err  out  1           1-cycle pulse, a stop bit sampled low
//  busy       out  1           high from accepted start edge until return to IDLE
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): data=0, valid=0, frame_err=0, busy=0, FSM=IDLE, sync flops=1,
//    tick counter=0. Reset mid-frame abandons the frame, no pulse emitted.
//  - line passes through 2-flop synchroniser (line_s); all decisions use line_s.
//  - tick: 1-cycle enable every TICK_DIV clks (no derived clocks). Counter cleared on start-edge detect.
//  - sample counter s (0..OVERSAMPLE-1) advances on tick; mid-bit sample when s==OVERSAMPLE/2-1.
//  - FSM: IDLE -> START on line_s falling edge (prev 1, now 0).
//    START: at mid-bit, line_s==0 -> DATA, else false start -> IDLE (no pulse).
//    DATA: one sample per bit at mid-bit into shift reg, LSB first; after DATA_WIDTH bits -> STOP.
//    STOP: sample each stop bit at mid-bit. All high -> data<=shift, valid=1, -> IDLE.
//      Any low -> frame_err=1, data unchanged, -> BREAK.
//    BREAK: wait for line_s==1, then -> IDLE (no new frame accepted while line held low).
//  - Return to IDLE at mid last stop bit; next start edge accepted immediately (tolerates
//    transmitter sending back-to-back frames with up to ~half-bit clock mismatch).
//  - Latency: valid asserts within 3 clks of mid-point of last stop bit (2 sync + 1 register).
//  - valid and frame_err never assert together; busy=0 in IDLE only.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined: each bit value = 2-of-3 majority of samples at s=OVERSAMPLE/2-2,
//    -1, 0 (mid and neighbours); start-bit check also uses majority. Single-sample glitch rejected.
//  Undefined: single sample at s==OVERSAMPLE/2-1; no extra sample registers.
// STRUCTURE
//  - Shared header uart_defs.vh: FSM state encodings (IDLE, START, DATA, STOP, BREAK) and
//    common frame constants (start level 0, stop/idle level 1) used by both uart_tx and uart_rx.
//  - One sub-module: uart_baud_tick (CLK_FREQ, BAUDRATE, OVERSAMPLE; ports clk, rst_n, clear, tick);
//    reusable as an enable generator for the transmitter.
// TESTING  (sim params CLK_FREQ=1600000, BAUDRATE=100000 -> TICK_DIV=1, 16 clk/bit)
//  1. Loopback from uart_tx, send 8'hA5 -> exactly one valid pulse, data=8'hA5, frame_err never 1.
//  2. Back-to-back 8'h00 then 8'hFF, no idle gap -> two valid pulses, data 8'h00 then 8'hFF.
//  3. Line low for 3 clks then high (false start) -> no valid, no frame_err, busy back to 0 by clk ~10.
//  4. Frame 8'h55 with stop bit driven 0, line held low 40 clks -> one frame_err, data keeps previous
//     value, no valid; new frame 8'h3C after line high -> valid, data=8'h3C.
//  5. rst_n low for 1 clk at data bit 4 of a frame -> outputs 0, no pulse; next clean 8'h81 received OK.
//  6. With UART_RX_MAJORITY_EN, 1-clk inverted glitch at mid of bit 2 of 8'hF0 -> data=8'hF0;
//     without macro same stimulus -> data=8'hF4.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver FSM state encodings, line levels and a 2-of-3 vote helper.
// The transmitter uses the same line levels, so the two loop back directly.
package uart_rx_pkg;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t ST_IDLE  = 3'd0;
  localparam rx_state_t ST_START = 3'd1;
  localparam rx_state_t ST_DATA  = 3'd2;
  localparam rx_state_t ST_STOP  = 3'd3;
  localparam rx_state_t ST_BREAK = 3'd4;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, received word and status pulses out.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  line;
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  frame_err;
  logic                  busy;

  modport master (input line, output data, output valid, output frame_err, output busy);
  modport slave  (output line, input data, input valid, input frame_err, input busy);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample enable generator: one-cycle tick every CLK_FREQ/(BAUDRATE*OVERSAMPLE) clocks.
// clear restarts the period so the first tick lands a full period after a start edge.
module uart_baud_tick #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUDRATE   = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int TICK_DIV = CLK_FREQ / (BAUDRATE * OVERSAMPLE);
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronised line, oversampled start/data/stop framing, 1-cycle valid/frame_err.
// Optional macro UART_RX_MAJORITY_EN votes 2-of-3 samples around each bit centre.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ      = 50000000,
  parameter int BAUDRATE      = 9600,
  parameter int DATA_WIDTH    = 8,
  parameter int STOP_BIT_SIZE = 1,
  parameter int OVERSAMPLE    = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.master rx_bus
);
  localparam int MID = OVERSAMPLE / 2 - 1;
`ifdef UART_RX_MAJORITY_EN
  // Decide one tick after centre so the sample just past mid-bit is available.
  localparam int DECIDE = MID + 1;
`else
  localparam int DECIDE = MID;
`endif
  localparam int S_W   = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [S_W-1:0]   S_LAST    = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0]   S_DECIDE  = S_W'(DECIDE);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BIT_SIZE - 1);

  logic                  sync1_q, sync1_d, line_s_q, line_s_d, line_prev_q, line_prev_d;
  rx_state_t             state_q, state_d;
  logic [S_W-1:0]        s_q, s_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, data_q, data_d;
  logic                  valid_q, valid_d, frame_err_q, frame_err_d;
  logic                  tick, tick_clear, sample_now, bit_val;

  uart_baud_tick #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUDRATE   (BAUDRATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tick_clear),
    .tick  (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  localparam logic [S_W-1:0] S_PRE2 = S_W'(DECIDE - 2);
  localparam logic [S_W-1:0] S_PRE1 = S_W'(DECIDE - 1);
  logic samp_a_q, samp_a_d, samp_b_q, samp_b_d;

  always_comb begin
    samp_a_d = samp_a_q;
    samp_b_d = samp_b_q;
    if (tick && s_q == S_PRE2) samp_a_d = line_s_q;
    if (tick && s_q == S_PRE1) samp_b_d = line_s_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp_a_q <= IDLE_LEVEL;
      samp_b_q <= IDLE_LEVEL;
    end else begin
      samp_a_q <= samp_a_d;
      samp_b_q <= samp_b_d;
    end
  end

  assign bit_val = maj3(samp_a_q, samp_b_q, line_s_q);
`else
  assign bit_val = line_s_q;
`endif

  assign sample_now = tick && (s_q == S_DECIDE);

  always_comb begin
    sync1_d     = rx_bus.line;
    line_s_d    = sync1_q;
    line_prev_d = line_s_q;
    state_d     = state_q;
    s_d         = s_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    tick_clear  = 1'b0;

    // s keeps running across bit boundaries so every bit is exactly OVERSAMPLE ticks wide.
    if (tick) s_d = (s_q == S_LAST) ? '0 : s_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        s_d   = '0;
        bit_d = '0;
        if (line_prev_q && !line_s_q) begin
          state_d    = ST_START;
          tick_clear = 1'b1;
        end
      end
      ST_START: begin
        if (sample_now) state_d = (bit_val == START_LEVEL) ? ST_DATA : ST_IDLE;
      end
      ST_DATA: begin
        if (sample_now) begin
          shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (sample_now) begin
          if (bit_val != STOP_LEVEL) begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end else if (bit_q == STOP_LAST) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (line_s_q == IDLE_LEVEL) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= IDLE_LEVEL;
      line_s_q    <= IDLE_LEVEL;
      line_prev_q <= IDLE_LEVEL;
      state_q     <= ST_IDLE;
      s_q         <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      line_s_q    <= line_s_d;
      line_prev_q <= line_prev_d;
      state_q     <= state_d;
      s_q         <= s_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_bus.data      = data_q;
  assign rx_bus.valid     = valid_q;
  assign rx_bus.frame_err = frame_err_q;
  assign rx_bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random traffic against an event scoreboard.
// Expected data under a mid-bit glitch depends on UART_RX_MAJORITY_EN.
module tb_uart_rx;
  localparam int CLK_FREQ = 1600000;
  localparam int BAUDRATE = 100000;
  localparam int DW       = 8;
  localparam int BIT_CLKS = 16;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } evt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  evt_t exp_q[$];
  logic [7:0] model_data = 8'h00;

  uart_rx_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx #(
    .CLK_FREQ      (CLK_FREQ),
    .BAUDRATE      (BAUDRATE),
    .DATA_WIDTH    (DW),
    .STOP_BIT_SIZE (1),
    .OVERSAMPLE    (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every valid/frame_err pulse must match the oldest expected frame outcome.
  always @(negedge clk) begin
    evt_t e;
    if (rst_n) begin
      if (bus.valid || bus.frame_err) begin
        check_eq("valid_ferr_excl", 32'(bus.valid & bus.frame_err), 0);
        check_eq("evt_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("evt_kind", 32'(bus.frame_err), 32'(e.is_err));
          if (!e.is_err) begin
            check_eq("rx_data", 32'(bus.data), 32'(e.data));
            model_data = e.data;
            $display("rx frame: valid data=%02h expected=%02h", bus.data, e.data);
          end else begin
            check_eq("ferr_data_hold", 32'(bus.data), 32'(model_data));
            $display("rx frame: frame_err data=%02h", bus.data);
          end
        end
      end else if (bus.data !== model_data) begin
        check_eq("data_hold", 32'(bus.data), 32'(model_data));
      end
    end
  end

  task automatic drive(input logic v, input int n);
    bus.line = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Behavioural transmitter; glitch_bit >= 0 inverts that data bit for one clock at its centre.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int glitch_bit);
    drive(1'b0, BIT_CLKS);
    for (int i = 0; i < DW; i++) begin
      if (i == glitch_bit) begin
        drive(b[i], 8);
        drive(~b[i], 1);
        drive(b[i], 7);
      end else begin
        drive(b[i], BIT_CLKS);
      end
    end
    drive(stop_ok ? 1'b1 : 1'b0, BIT_CLKS);
  endtask

  task automatic expect_good(input logic [7:0] b);
    evt_t e;
    e.is_err = 1'b0;
    e.data   = b;
    exp_q.push_back(e);
  endtask

  task automatic expect_err();
    evt_t e;
    e.is_err = 1'b1;
    e.data   = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (!bus.busy && exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_busy"}, 32'(bus.busy), 0);
    check_eq({tag, "_pending"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] glitch_exp;
    bit         bad;
    int         gap;

    bus.line = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data", 32'(bus.data), 0);
    check_eq("rst_valid", 32'(bus.valid), 0);
    check_eq("rst_ferr", 32'(bus.frame_err), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    drive(1'b1, 20);

    // single frame
    expect_good(8'hA5);
    send_frame(8'hA5, 1'b1, -1);
    wait_idle("t1");
    check_eq("t1_data", 32'(bus.data), 32'h A5);

    // back-to-back, no idle gap
    expect_good(8'h00);
    expect_good(8'hFF);
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    drive(1'b1, 10);
    wait_idle("t2");
    check_eq("t2_data", 32'(bus.data), 32'h FF);

    // false start: 3-clock low pulse
    drive(1'b0, 3);
    drive(1'b1, 1);
    check_eq("t3_busy_hi", 32'(bus.busy), 1);
    drive(1'b1, 10);
    check_eq("t3_busy_lo", 32'(bus.busy), 0);
    wait_idle("t3");

    // bad stop bit, line held low, then recovery
    expect_err();
    send_frame(8'h55, 1'b0, -1);
    drive(1'b0, 40);
    check_eq("t4_busy_break", 32'(bus.busy), 1);
    check_eq("t4_data_kept", 32'(bus.data), 32'h FF);
    drive(1'b1, 20);
    wait_idle("t4a");
    expect_good(8'h3C);
    send_frame(8'h3C, 1'b1, -1);
    wait_idle("t4b");
    check_eq("t4_data", 32'(bus.data), 32'h 3C);

    // reset mid-frame at data bit 4
    b = 8'($urandom_range(0, 255));
    drive(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive(b[i], BIT_CLKS);
    drive(b[4], 8);
    rst_n       = 1'b0;
    bus.line    = 1'b1;
    model_data  = 8'h00;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("t5_data", 32'(bus.data), 0);
    check_eq("t5_busy", 32'(bus.busy), 0);
    check_eq("t5_valid", 32'(bus.valid), 0);
    drive(1'b1, 30);
    expect_good(8'h81);
    send_frame(8'h81, 1'b1, -1);
    wait_idle("t5");
    check_eq("t5_data_after", 32'(bus.data), 32'h 81);

    // one-clock glitch at centre of bit 2
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'hF0;
`else
    glitch_exp = 8'hF4;
`endif
    expect_good(glitch_exp);
    send_frame(8'hF0, 1'b1, 2);
    wait_idle("t6");
    check_eq("t6_data", 32'(bus.data), 32'(glitch_exp));

    // random traffic
    for (int n = 0; n < 30; n++) begin
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 7) == 0);
      gap = $urandom_range(0, 24);
      if (bad) begin
        expect_err();
        send_frame(b, 1'b0, -1);
        drive(1'b0, $urandom_range(0, 30));
        drive(1'b1, BIT_CLKS + gap);
      end else begin
        expect_good(b);
        send_frame(b, 1'b1, -1);
        drive(1'b1, gap);
      end
    end
    drive(1'b1, 10);
    wait_idle("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
